// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, latencies and state encoding.
package md_unit_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [3:0] MULT_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES  = 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  // Ops that occupy the unit for several cycles (everything up to DIVU).
  function automatic logic is_long_op(input logic [2:0] op);
    return (op <= OP_DIVU);
  endfunction

endpackage

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers and pipeline stall request.
// Results are computed at issue, held in temp_hi/temp_lo, and committed after the latency expires.
module md_unit
  import md_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        E_start,
  input  logic [2:0]  E_md_op,
  input  logic [31:0] E_rs_val,
  input  logic [31:0] E_rt_val,
  input  logic        E_hilo_sel,
  input  logic        D_md_use,
  output logic [31:0] E_hilo_out,
  output logic        Busy,
  output logic        MD_Stall
);

  md_state_e   state_q;
  logic [3:0]  counter_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] temp_hi_q, temp_lo_q;
  logic        no_commit_q;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] quo_s, rem_s;
  logic        [31:0] quo_u, rem_u;
  logic               div_zero;

  assign div_zero = (E_rt_val == 32'd0);

  always_comb begin
    prod_s = $signed(E_rs_val) * $signed(E_rt_val);
    prod_u = {32'd0, E_rs_val} * {32'd0, E_rt_val};
    quo_s  = '0;
    rem_s  = '0;
    quo_u  = '0;
    rem_u  = '0;
    if (!div_zero) begin
      // Most-negative / -1 overflows; the architectural answer is the dividend with zero remainder.
      if (E_rs_val == 32'h8000_0000 && E_rt_val == 32'hFFFF_FFFF) begin
        quo_s = $signed(E_rs_val);
        rem_s = '0;
      end else begin
        quo_s = $signed(E_rs_val) / $signed(E_rt_val);
        rem_s = $signed(E_rs_val) % $signed(E_rt_val);
      end
      quo_u = E_rs_val / E_rt_val;
      rem_u = E_rs_val % E_rt_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      counter_q   <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      temp_hi_q   <= '0;
      temp_lo_q   <= '0;
      no_commit_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (E_start) begin
            case (E_md_op)
              OP_MULT: begin
                temp_hi_q   <= prod_s[63:32];
                temp_lo_q   <= prod_s[31:0];
                counter_q   <= MULT_CYCLES;
                no_commit_q <= 1'b0;
                state_q     <= ST_BUSY;
              end
              OP_MULTU: begin
                temp_hi_q   <= prod_u[63:32];
                temp_lo_q   <= prod_u[31:0];
                counter_q   <= MULT_CYCLES;
                no_commit_q <= 1'b0;
                state_q     <= ST_BUSY;
              end
              OP_DIV: begin
                if (!div_zero) begin
                  temp_hi_q <= rem_s;
                  temp_lo_q <= quo_s;
                end
                counter_q   <= DIV_CYCLES;
                no_commit_q <= div_zero;
                state_q     <= ST_BUSY;
              end
              OP_DIVU: begin
                if (!div_zero) begin
                  temp_hi_q <= rem_u;
                  temp_lo_q <= quo_u;
                end
                counter_q   <= DIV_CYCLES;
                no_commit_q <= div_zero;
                state_q     <= ST_BUSY;
              end
              OP_MTHI: hi_q <= E_rs_val;
              OP_MTLO: lo_q <= E_rs_val;
              default: ;
            endcase
          end
        end
        ST_BUSY: begin
          if (counter_q == 4'd1) begin
            if (!no_commit_q) begin
              hi_q <= temp_hi_q;
              lo_q <= temp_lo_q;
            end
            counter_q <= '0;
            state_q   <= ST_IDLE;
          end else begin
            counter_q <= counter_q - 4'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Busy       = (state_q == ST_BUSY);
  assign MD_Stall   = D_md_use & (Busy | (E_start & is_long_op(E_md_op)));
  assign E_hilo_out = E_hilo_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit: latency, results, stall, MT writes and reset behaviour.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        E_start;
  logic [2:0]  E_md_op;
  logic [31:0] E_rs_val;
  logic [31:0] E_rt_val;
  logic        E_hilo_sel;
  logic        D_md_use;
  logic [31:0] E_hilo_out;
  logic        Busy;
  logic        MD_Stall;

  int n_checks = 0;
  int n_fail   = 0;

  md_unit dut (
    .clk        (clk),
    .reset      (reset),
    .E_start    (E_start),
    .E_md_op    (E_md_op),
    .E_rs_val   (E_rs_val),
    .E_rt_val   (E_rt_val),
    .E_hilo_sel (E_hilo_sel),
    .D_md_use   (D_md_use),
    .E_hilo_out (E_hilo_out),
    .Busy       (Busy),
    .MD_Stall   (MD_Stall)
  );

  always #5 clk = ~clk;

  // Drive a one-cycle start from a negedge; returns at the following negedge.
  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    E_md_op  = op;
    E_rs_val = rs;
    E_rt_val = rt;
    E_start  = 1'b1;
    @(negedge clk);
    E_start  = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (Busy === 1'b1 && n < 30) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; E_start = 1'b1; E_md_op = 3'd0; E_rs_val = 32'd3; E_rt_val = 32'd4;
    E_hilo_sel = 1'b0; D_md_use = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", Busy); end
    n_checks++; if (MD_Stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall: got %b exp 1", MD_Stall); end
    n_checks++; if (E_hilo_out !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h exp 0", E_hilo_out); end
    E_hilo_sel = 1'b1; #1;
    n_checks++; if (E_hilo_out !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h exp 0", E_hilo_out); end
    E_md_op = 3'd6; #1;
    n_checks++; if (MD_Stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall_op6: got %b exp 0", MD_Stall); end
    E_start = 1'b0; D_md_use = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_prio_busy: got %b exp 0", Busy); end
  endtask

  task automatic test_mult;
    int n;
    issue(3'd0, 32'd3, 32'd4);
    E_hilo_sel = 1'b0; #1;
    n_checks++; if (E_hilo_out !== 32'd0) begin n_fail++; $display("FAIL mult_inflight_lo: got %h exp 0", E_hilo_out); end
    count_busy(n);
    n_checks++; if (n !== 5) begin n_fail++; $display("FAIL mult_latency: got %0d exp 5", n); end
    E_hilo_sel = 1'b1; #1;
    n_checks++; if (E_hilo_out !== 32'h0000_0000) begin n_fail++; $display("FAIL mult_hi: got %h exp 00000000", E_hilo_out); end
    E_hilo_sel = 1'b0; #1;
    n_checks++; if (E_hilo_out !== 32'h0000_000C) begin n_fail++; $display("FAIL mult_lo: got %h exp 0000000c", E_hilo_out); end
  endtask

  task automatic test_multu;
    int n;
    @(negedge clk);
    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    count_busy(n);
    n_checks++; if (n !== 5) begin n_fail++; $display("FAIL multu_latency: got %0d exp 5", n); end
    E_hilo_sel = 1'b1; #1;
    n_checks++; if (E_hilo_out !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_hi: got %h exp 00000001", E_hilo_out); end
    E_hilo_sel = 1'b0; #1;
    n_checks++; if (E_hilo_out !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_lo: got %h exp fffffffe", E_hilo_out); end
    @(negedge clk);
    issue(3'd0, 32'hFFFF_FFFF, 32'd2);
    count_busy(n);
    E_hilo_sel = 1'b1; #1;
    n_checks++; if (E_hilo_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mults_hi: got %h exp ffffffff", E_hilo_out); end
    E_hilo_sel = 1'b0; #1;
    n_checks++; if (E_hilo_out !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mults_lo: got %h exp fffffffe", E_hilo_out); end
  endtask

  task automatic test_div;
    int n;
    @(negedge clk);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    count_busy(n);
    n_checks++; if (n !== 10) begin n_fail++; $display("FAIL div_latency: got %0d exp 10", n); end
    E_hilo_sel = 1'b0; #1;
    n_checks++; if (E_hilo_out !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo: got %h exp fffffffd", E_hilo_out); end
    E_hilo_sel = 1'b1; #1;
    n_checks++; if (E_hilo_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi: got %h exp ffffffff", E_hilo_out); end
    @(negedge clk);
    issue(3'd3, 32'd7, 32'd0);
    count_busy(n);
    n_checks++; if (n !== 10) begin n_fail++; $display("FAIL divu0_latency: got %0d exp 10", n); end
    E_hilo_sel = 1'b1; #1;
    n_checks++; if (E_hilo_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu0_hi: got %h exp ffffffff", E_hilo_out); end
    E_hilo_sel = 1'b0; #1;
    n_checks++; if (E_hilo_out !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL divu0_lo: got %h exp fffffffd", E_hilo_out); end
  endtask

  task automatic test_mt;
    int n;
    @(negedge clk);
    issue(3'd5, 32'h0000_1234, 32'd0);
    E_hilo_sel = 1'b0; #1;
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL mtlo_busy: got %b exp 0", Busy); end
    n_checks++; if (E_hilo_out !== 32'h0000_1234) begin n_fail++; $display("FAIL mtlo_lo: got %h exp 00001234", E_hilo_out); end
    @(negedge clk);
    issue(3'd2, 32'd100, 32'd7);
    @(negedge clk);
    issue(3'd4, 32'h0000_DEAD, 32'd0);
    E_hilo_sel = 1'b1; #1;
    n_checks++; if (E_hilo_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mthi_busy_hi: got %h exp ffffffff", E_hilo_out); end
    count_busy(n);
    n_checks++; if (n !== 8) begin n_fail++; $display("FAIL mthi_busy_remaining: got %0d exp 8", n); end
    E_hilo_sel = 1'b1; #1;
    n_checks++; if (E_hilo_out !== 32'd2) begin n_fail++; $display("FAIL div_rem_after_mthi: got %h exp 00000002", E_hilo_out); end
    E_hilo_sel = 1'b0; #1;
    n_checks++; if (E_hilo_out !== 32'd14) begin n_fail++; $display("FAIL div_quo_after_mthi: got %h exp 0000000e", E_hilo_out); end
  endtask

  task automatic test_stall;
    int n;
    int bad;
    @(negedge clk);
    D_md_use = 1'b1;
    E_md_op = 3'd0; E_rs_val = 32'd5; E_rt_val = 32'd6; E_start = 1'b1; #1;
    n_checks++; if (MD_Stall !== 1'b1) begin n_fail++; $display("FAIL stall_start: got %b exp 1", MD_Stall); end
    @(negedge clk);
    E_start = 1'b0; #1;
    n = 0;
    while (MD_Stall === 1'b1 && n < 30) begin
      n++;
      @(negedge clk);
    end
    n_checks++; if (n !== 5) begin n_fail++; $display("FAIL stall_cycles: got %0d exp 5", n); end
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL stall_end_busy: got %b exp 0", Busy); end
    D_md_use = 1'b0;
    E_start = 1'b1; #1;
    bad = (MD_Stall === 1'b1) ? 1 : 0;
    @(negedge clk);
    E_start = 1'b0;
    repeat (6) begin
      #1;
      if (MD_Stall !== 1'b0) bad++;
      @(negedge clk);
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL stall_no_use: got %0d stalled samples exp 0", bad); end
  endtask

  task automatic test_reset_mid;
    issue(3'd2, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b exp 0", Busy); end
    E_hilo_sel = 1'b1; #1;
    n_checks++; if (E_hilo_out !== 32'd0) begin n_fail++; $display("FAIL midreset_hi: got %h exp 0", E_hilo_out); end
    E_hilo_sel = 1'b0; #1;
    n_checks++; if (E_hilo_out !== 32'd0) begin n_fail++; $display("FAIL midreset_lo: got %h exp 0", E_hilo_out); end
    repeat (12) @(negedge clk);
    E_hilo_sel = 1'b1; #1;
    n_checks++; if (E_hilo_out !== 32'd0) begin n_fail++; $display("FAIL midreset_late_hi: got %h exp 0", E_hilo_out); end
    E_hilo_sel = 1'b0; #1;
    n_checks++; if (E_hilo_out !== 32'd0) begin n_fail++; $display("FAIL midreset_late_lo: got %h exp 0", E_hilo_out); end
  endtask

  task automatic test_back_to_back;
    int n;
    @(negedge clk);
    issue(3'd0, 32'd3, 32'd4);
    count_busy(n);
    n_checks++; if (n !== 5) begin n_fail++; $display("FAIL b2b_first_latency: got %0d exp 5", n); end
    issue(3'd1, 32'h0001_0000, 32'h0001_0000);
    count_busy(n);
    n_checks++; if (n !== 5) begin n_fail++; $display("FAIL b2b_second_latency: got %0d exp 5", n); end
    E_hilo_sel = 1'b1; #1;
    n_checks++; if (E_hilo_out !== 32'd1) begin n_fail++; $display("FAIL b2b_hi: got %h exp 00000001", E_hilo_out); end
    E_hilo_sel = 1'b0; #1;
    n_checks++; if (E_hilo_out !== 32'd0) begin n_fail++; $display("FAIL b2b_lo: got %h exp 00000000", E_hilo_out); end
    @(negedge clk);
    issue(3'd6, 32'h5555_5555, 32'd1);
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL op6_busy: got %b exp 0", Busy); end
    E_hilo_sel = 1'b1; #1;
    n_checks++; if (E_hilo_out !== 32'd1) begin n_fail++; $display("FAIL op6_hi: got %h exp 00000001", E_hilo_out); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_mt();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
